// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch unit bus: imem request/response, redirect and decode handshake
interface instr_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - credit-limited instruction prefetch queue with redirect flush
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic         clk,
    input  logic         rst,
    instr_fetch_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t        DEPTH_C = cnt_t'(DEPTH);
    localparam logic [CW:0] CAP     = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    cnt_t          count;
    cnt_t          outstanding;
    cnt_t          discard;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q    [DEPTH];

    logic [CW:0]   in_flight;
    logic [31:0]   target;
    logic          redirect;
    logic          req_fire;
    logic          resp;
    logic          push;
    logic          pop;
    logic          unused_lsb;

    assign redirect   = bus.redirect_valid;
    assign target     = {bus.redirect_pc[31:2], 2'b00};
    assign unused_lsb = ^bus.redirect_pc[1:0];
    assign in_flight  = {1'b0, count} + {1'b0, outstanding};

    // Queued plus outstanding words never exceed DEPTH, so a response always has a free slot.
    assign bus.imem_req_valid = !rst && !redirect && (in_flight < CAP);
    assign bus.imem_req_addr  = fetch_pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    assign resp = bus.imem_resp_valid;
    assign push = resp && !redirect && (discard == '0);
    assign pop  = bus.if_valid && bus.if_ready && !redirect;

    assign bus.if_valid = (count != '0);
    assign bus.if_instr = instr_q[rd_ptr];
    assign bus.if_pc    = pc_q[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= RESET_PC;
            end
        end else begin
            outstanding <= outstanding + cnt_t'(req_fire) - cnt_t'(resp);
            if (redirect) begin
                // Every word still pending after this cycle belongs to the old path.
                fetch_pc <= target;
                resp_pc  <= target;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                discard  <= outstanding - cnt_t'(resp);
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + 32'd4;
                if (resp && (discard != '0))
                    discard <= discard - cnt_t'(1);
                if (push) begin
                    instr_q[wr_ptr] <= bus.imem_resp_data;
                    pc_q[wr_ptr]    <= resp_pc;
                    wr_ptr          <= wr_ptr + AW'(1);
                    resp_pc         <= resp_pc + 32'd4;
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count + cnt_t'(push) - cnt_t'(pop);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) push |-> (count < DEPTH_C));
    a_credit:      assert property (@(posedge clk) disable iff (rst) in_flight <= CAP);
    a_discard:     assert property (@(posedge clk) disable iff (rst) discard <= outstanding);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized bench with a sequential-program reference model
module tb_instr_fetch_unit;
    logic clk;
    logic rst;

    instr_fetch_if if0 ();
    instr_fetch_if if1 ();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mq[$];
    int          checks, errors;
    int          cyc, last_due, lat_lo, lat_hi, ready_pct, ifr_pct, npop;
    logic        redir_req;
    logic [31:0] redir_target;
    logic [31:0] exp_fetch, exp_pc, pop_pc;
    logic        fire_f, pop_f, resp_f, ifv_f;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic idle_inputs();
        if0.imem_req_ready = 1'b0; if0.imem_resp_valid = 1'b0; if0.imem_resp_data = '0;
        if0.redirect_valid = 1'b0; if0.redirect_pc = '0;       if0.if_ready = 1'b0;
        if1.imem_req_ready = 1'b0; if1.imem_resp_valid = 1'b0; if1.imem_resp_data = '0;
        if1.redirect_valid = 1'b0; if1.redirect_pc = '0;       if1.if_ready = 1'b0;
    endtask

    // Memory is reset together with the fetch unit; release lands on a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        mq.delete();
        cyc = 0; last_due = 0; npop = 0;
        redir_req = 1'b0; redir_target = '0;
        exp_fetch = 32'h0; exp_pc = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One cycle of dut0: drive, sample 1 time unit later, update the program-order model.
    task automatic step();
        int d;
        if0.imem_req_ready = (int'($urandom_range(99, 0)) < ready_pct);
        if0.if_ready       = (int'($urandom_range(99, 0)) < ifr_pct);
        if0.redirect_valid = redir_req;
        if0.redirect_pc    = redir_target;
        resp_f = 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            resp_f = 1'b1;
            if0.imem_resp_valid = 1'b1;
            if0.imem_resp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            if0.imem_resp_valid = 1'b0;
            if0.imem_resp_data  = $urandom;
        end
        #1;
        ifv_f  = if0.if_valid;
        fire_f = if0.imem_req_valid && if0.imem_req_ready;
        pop_f  = if0.if_valid && if0.if_ready && !redir_req;
        if (redir_req) begin
            checks++;
            if (if0.imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL redirect_blocks_req: imem_req_valid=%b required 0", if0.imem_req_valid);
            end
        end
        if (fire_f) begin
            checks++;
            if (if0.imem_req_addr !== exp_fetch) begin
                errors++;
                $display("FAIL req_addr: got %h required %h (cycle %0d)", if0.imem_req_addr, exp_fetch, cyc);
            end
            d = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (d < last_due) d = last_due;
            last_due = d;
            mq.push_back('{addr: if0.imem_req_addr, due: d});
            exp_fetch = exp_fetch + 32'd4;
        end
        if (ifv_f && !redir_req) begin
            checks++;
            if (if0.if_pc !== exp_pc || if0.if_instr !== mem_word(exp_pc)) begin
                errors++;
                $display("FAIL head: if_pc=%h if_instr=%h required %h %h (cycle %0d)",
                         if0.if_pc, if0.if_instr, exp_pc, mem_word(exp_pc), cyc);
            end
        end
        if (pop_f) begin
            pop_pc = if0.if_pc;
            exp_pc = exp_pc + 32'd4;
            npop++;
        end
        if (redir_req) begin
            exp_pc    = {redir_target[31:2], 2'b00};
            exp_fetch = {redir_target[31:2], 2'b00};
        end
        redir_req = 1'b0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        checks += 5;
        if (if0.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b required 0", if0.imem_req_valid); end
        if (if0.if_valid !== 1'b0)       begin errors++; $display("FAIL reset_if_valid: got %b required 0", if0.if_valid); end
        if (if0.if_instr !== 32'h0)      begin errors++; $display("FAIL reset_if_instr: got %h required 0", if0.if_instr); end
        if (if0.if_pc !== 32'h0)         begin errors++; $display("FAIL reset_if_pc: got %h required 0", if0.if_pc); end
        if (if1.if_pc !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_if_pc_alt: got %h required fffffff8", if1.if_pc); end
        do_reset();
    endtask

    task automatic test_basic();
        ready_pct = 100; ifr_pct = 100; lat_lo = 1; lat_hi = 1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            if (i < 3) begin
                checks++;
                if (fire_f !== 1'b1) begin errors++; $display("FAIL basic_issue: step %0d fire=%b required 1", i, fire_f); end
            end
            if (i >= 2) begin
                checks++;
                if (pop_f !== 1'b1) begin errors++; $display("FAIL basic_stream: step %0d pop=%b required 1", i, pop_f); end
            end
        end
    endtask

    task automatic test_backpressure();
        int nfire;
        ready_pct = 100; ifr_pct = 0; lat_lo = 1; lat_hi = 1;
        do_reset();
        nfire = 0;
        repeat (10) begin step(); nfire += int'(fire_f); end
        checks += 2;
        if (nfire != 4) begin errors++; $display("FAIL bp_requests: got %0d required 4", nfire); end
        if (if0.imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b required 0", if0.imem_req_valid); end
        ifr_pct = 100; npop = 0;
        repeat (20) step();
        checks++;
        if (npop != 20) begin errors++; $display("FAIL bp_resume: got %0d pops required 20", npop); end
    endtask

    task automatic test_redirect();
        logic found;
        ready_pct = 100; ifr_pct = 100; lat_lo = 3; lat_hi = 3;
        do_reset();
        step(); step();
        checks++;
        if (mq.size() != 2) begin errors++; $display("FAIL redir_outstanding: got %0d required 2", mq.size()); end
        ready_pct = 0; redir_req = 1'b1; redir_target = 32'h0000_0100;
        step();
        ready_pct = 100;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (pop_f) found = 1'b1;
        end
        checks++;
        if (!found || pop_pc !== 32'h100) begin
            errors++;
            $display("FAIL redir_first_pc: found=%b pc=%h required 00000100", found, pop_pc);
        end
    endtask

    task automatic test_redirect_collide();
        int   exp_disc;
        logic found;
        ready_pct = 100; ifr_pct = 100; lat_lo = 2; lat_hi = 2;
        do_reset();
        repeat (6) step();
        redir_req = 1'b1; redir_target = 32'h2000_0043;
        step();
        exp_disc = mq.size();
        checks += 3;
        if (!(resp_f && ifv_f)) begin errors++; $display("FAIL collide_setup: resp=%b if_valid=%b required 1 1", resp_f, ifv_f); end
        if (if0.if_valid !== 1'b0) begin errors++; $display("FAIL collide_flush: if_valid=%b required 0", if0.if_valid); end
        if (dut0.discard !== 3'(exp_disc)) begin errors++; $display("FAIL collide_discard: got %0d required %0d", dut0.discard, exp_disc); end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (pop_f) found = 1'b1;
        end
        checks++;
        if (!found || pop_pc !== 32'h2000_0040) begin
            errors++;
            $display("FAIL collide_first_pc: found=%b pc=%h required 20000040", found, pop_pc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] pend[$];
        logic [31:0] w_fetch, w_pc;
        int          nfire, nwpop;
        do_reset();
        w_fetch = 32'hFFFF_FFF8; w_pc = 32'hFFFF_FFF8; nfire = 0; nwpop = 0;
        for (int i = 0; i < 8; i++) begin
            if1.imem_req_ready = 1'b1;
            if1.if_ready       = 1'b1;
            if (pend.size() > 0) begin
                if1.imem_resp_valid = 1'b1;
                if1.imem_resp_data  = mem_word(pend.pop_front());
            end else begin
                if1.imem_resp_valid = 1'b0;
            end
            #1;
            if (if1.imem_req_valid && if1.imem_req_ready) begin
                checks++;
                if (if1.imem_req_addr !== w_fetch) begin errors++; $display("FAIL wrap_addr: got %h required %h", if1.imem_req_addr, w_fetch); end
                pend.push_back(if1.imem_req_addr);
                w_fetch = w_fetch + 32'd4;
                nfire++;
            end
            if (if1.if_valid) begin
                checks++;
                if (if1.if_pc !== w_pc || if1.if_instr !== mem_word(w_pc)) begin
                    errors++;
                    $display("FAIL wrap_head: if_pc=%h if_instr=%h required %h %h", if1.if_pc, if1.if_instr, w_pc, mem_word(w_pc));
                end
                w_pc = w_pc + 32'd4;
                nwpop++;
            end
            @(negedge clk);
        end
        checks++;
        if (nfire != 8 || nwpop != 6) begin errors++; $display("FAIL wrap_counts: fires=%0d pops=%0d required 8 6", nfire, nwpop); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        ready_pct = 100; ifr_pct = 0; lat_lo = 3; lat_hi = 3;
        do_reset();
        repeat (5) step();
        checks += 2;
        if (if0.if_valid !== 1'b1) begin errors++; $display("FAIL midrst_setup_valid: got %b required 1", if0.if_valid); end
        if (mq.size() != 2) begin errors++; $display("FAIL midrst_setup_outstanding: got %0d required 2", mq.size()); end
        #3 rst = 1'b1;
        #1;
        checks += 4;
        if (if0.imem_req_valid !== 1'b0) begin errors++; $display("FAIL midrst_req_valid: got %b required 0", if0.imem_req_valid); end
        if (if0.if_valid !== 1'b0)       begin errors++; $display("FAIL midrst_if_valid: got %b required 0", if0.if_valid); end
        if (if0.if_instr !== 32'h0)      begin errors++; $display("FAIL midrst_if_instr: got %h required 0", if0.if_instr); end
        if (if0.if_pc !== 32'h0)         begin errors++; $display("FAIL midrst_if_pc: got %h required 0", if0.if_pc); end
        ifr_pct = 100; lat_lo = 1; lat_hi = 1;
        do_reset();
        step();
        checks++;
        if (fire_f !== 1'b1) begin errors++; $display("FAIL midrst_restart: fire=%b required 1", fire_f); end
        repeat (9) step();
        checks++;
        if (npop == 0) begin errors++; $display("FAIL midrst_stream: got 0 pops required >0"); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 100 == 0) begin
                ready_pct = int'($urandom_range(100, 30));
                ifr_pct   = int'($urandom_range(100, 20));
                lat_lo    = int'($urandom_range(3, 1));
                lat_hi    = lat_lo + int'($urandom_range(2, 0));
            end
            if ($urandom_range(99, 0) < 4) begin
                redir_req    = 1'b1;
                redir_target = $urandom;
            end
            step();
        end
        checks++;
        if (npop < 50) begin errors++; $display("FAIL random_progress: got %0d pops required >=50", npop); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect();
        test_redirect_collide();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
